micro_ucr_nonce_ctrl: RTL and testbench
=======================================

MICRO_UCR_NONCE_CTRL -- requirements
Module: micro_ucr_nonce_ctrl

Interface
REQ-001 Parameter HASH_CYC, default 34: cycles per attempt in which the hash core runs with hash_fin=0.
REQ-002 Parameter NONCE_W, default 32: nonce width.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin a nonce search; sampled only in IDLE.
REQ-007 abort  in  1  terminate a search in progress.
REQ-008 header  in  96  fixed block header; latched on accepted start.
REQ-009 target  in  8  difficulty threshold; latched on accepted start.
REQ-010 max_nonce  in  NONCE_W  last nonce to try; latched on accepted start.
REQ-011 hash_H  in  24  hash result from the core.
REQ-012 hash_bloque  out  128  core block = {header_latched, nonce}, nonce in bits [31:0].
REQ-013 hash_reset_L  out  1  active-low core reset.
REQ-014 hash_fin  out  1  core hold; low only while the core runs.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at search end.
REQ-017 found  out  1  valid-hash flag, held until the next accepted start.
REQ-018 nonce_out  out  NONCE_W  last nonce checked (winning nonce if found).
REQ-019 hash_out  out  24  hash_H sampled at the last check.

Function
REQ-020 The FSM SHALL implement states IDLE, LOAD, HASH, CHECK and DONE.
- REQ-021 IDLE: start=1 and abort=0 -> LOAD; latch header, target and max_nonce; nonce=0; clear found, nonce_out and hash_out.
- REQ-022 LOAD, exactly 1 cycle: hash_reset_L=0, hash_bloque carries the current nonce; -> HASH.
- REQ-023 HASH: hash_reset_L=1, hash_fin=0; round counter 0..HASH_CYC-1; -> CHECK after HASH_CYC cycles.
- REQ-024 CHECK, 1 cycle: hash_fin=1; capture hash_H into hash_out and nonce into nonce_out.
- REQ-025 CHECK hit condition: hash_H[23:16] < target AND hash_H[15:8] < target, unsigned and strict.
- REQ-026 CHECK on hit: found=1, -> DONE.
- REQ-027 CHECK on miss with nonce == max_nonce: found=0, -> DONE.
- REQ-028 CHECK on miss otherwise: nonce+1, -> LOAD.
- REQ-029 DONE: done=1 for one cycle, -> IDLE.
REQ-030 hash_reset_L SHALL be 0 in IDLE, LOAD and DONE; hash_fin SHALL be 1 in every state except HASH.
REQ-031 Each attempt SHALL take HASH_CYC+2 cycles (36 by default); nonce increments SHALL NOT wrap, since max_nonce bounds the search; max_nonce=2^NONCE_W-1 SHALL terminate after that nonce is checked.
REQ-032 Latency with the start edge as cycle 0: CHECK of nonce N at cycle (N+1)*(HASH_CYC+2); done at that cycle +1.
REQ-033 abort=1 in LOAD, HASH or CHECK SHALL force IDLE on the next edge: no done pulse, found=0, nonce_out and hash_out keep their last captured values.
REQ-034 abort=1 in IDLE or DONE SHALL have no effect, except that abort wins over a simultaneous start in IDLE.
REQ-035 start while busy SHALL be ignored; header, target and max_nonce changes while busy SHALL NOT affect the search.

Reset
REQ-036 When reset asserts, asynchronously: state IDLE, busy=0, done=0, found=0, nonce_out=0, hash_out=0, hash_bloque=0, hash_reset_L=0, hash_fin=1, round counter 0, latched inputs 0.
REQ-037 Reset mid-search SHALL discard the search without a done pulse; the first start after reset deasserts SHALL be accepted normally.

Verification (core replaced by a stub driving hash_H as a function of nonce)
REQ-038 Stub H=24'h000000, target=8'h10, start -> done at cycle 37, found=1, nonce_out=0, hash_out=24'h000000.
REQ-039 Stub H=24'h0505FF only when nonce==3, else 24'hFFFFFF; target=8'h10 -> done at cycle 145, found=1, nonce_out=3.
REQ-040 Stub H=24'h10_00_00, target=8'h10, max_nonce=2 -> strict compare misses; done at cycle 109, found=0, nonce_out=2.
REQ-041 abort at cycle 20, inside HASH -> IDLE at cycle 21, hash_reset_L=0, busy=0, no done pulse; a new start afterwards completes normally.
REQ-042 reset pulsed mid-HASH -> all outputs take their REQ-036 values without waiting for a clock edge; start at the same cycle as abort -> request ignored.
REQ-043 During HASH, toggle header and start -> hash_bloque[127:32] unchanged and no restart.

Source files
------------

// File: rtl/micro_ucr_nonce_ctrl_if.sv
// Bundle of host-side controls and hash-core signals for the nonce search controller.
// master drives the request and returns the core hash; slave is the controller itself.
interface micro_ucr_nonce_ctrl_if #(
    parameter int NONCE_W = 32
);
    logic               start;
    logic               abort;
    logic [95:0]        header;
    logic [7:0]         target;
    logic [NONCE_W-1:0] max_nonce;
    logic [23:0]        hash_H;
    logic [127:0]       hash_bloque;
    logic               hash_reset_L;
    logic               hash_fin;
    logic               busy;
    logic               done;
    logic               found;
    logic [NONCE_W-1:0] nonce_out;
    logic [23:0]        hash_out;

    modport master (
        output start, abort, header, target, max_nonce, hash_H,
        input  hash_bloque, hash_reset_L, hash_fin, busy, done, found, nonce_out, hash_out
    );

    modport slave (
        input  start, abort, header, target, max_nonce, hash_H,
        output hash_bloque, hash_reset_L, hash_fin, busy, done, found, nonce_out, hash_out
    );
endinterface

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce search controller: walks nonces 0..max_nonce through an external hash core
// and stops at the first hash whose two upper bytes are both below the target.
module micro_ucr_nonce_ctrl #(
    parameter int HASH_CYC = 34,
    parameter int NONCE_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    micro_ucr_nonce_ctrl_if.slave   bus
);
    localparam int RND_W = (HASH_CYC > 1) ? $clog2(HASH_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HASH  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [95:0]        header_q;
    logic [7:0]         target_q;
    logic [NONCE_W-1:0] max_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [RND_W-1:0]   rnd_q;
    logic               found_q;
    logic [NONCE_W-1:0] nonce_out_q;
    logic [23:0]        hash_out_q;

    logic accept, rnd_last, hit, last_nonce;
    logic busy_c, done_c, hash_reset_l_c, hash_fin_c;

    // Strict unsigned compare on both upper hash bytes; a byte equal to the target misses.
    function automatic logic is_hit(input logic [7:0] b_hi, input logic [7:0] b_mid,
                                    input logic [7:0] tgt);
        return (b_hi < tgt) && (b_mid < tgt);
    endfunction

    assign accept     = bus.start && !bus.abort;
    assign rnd_last   = (rnd_q == RND_W'(HASH_CYC - 1));
    assign hit        = is_hit(bus.hash_H[23:16], bus.hash_H[15:8], target_q);
    assign last_nonce = (nonce_q == max_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = LOAD;
            LOAD:  state_d = bus.abort ? IDLE : HASH;
            HASH:  if (bus.abort) state_d = IDLE;
                   else if (rnd_last) state_d = CHECK;
            CHECK: if (bus.abort) state_d = IDLE;
                   else if (hit || last_nonce) state_d = DONE;
                   else state_d = LOAD;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c         = 1'b1;
        done_c         = 1'b0;
        hash_reset_l_c = 1'b1;
        hash_fin_c     = 1'b1;
        case (state_q)
            IDLE: begin
                busy_c         = 1'b0;
                hash_reset_l_c = 1'b0;
            end
            LOAD:  hash_reset_l_c = 1'b0;
            HASH:  hash_fin_c     = 1'b0;
            CHECK: ;
            DONE: begin
                done_c         = 1'b1;
                hash_reset_l_c = 1'b0;
            end
            default: ;
        endcase
    end

    // Search datapath: latched request, nonce walk, round counter and captured result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            header_q    <= '0;
            target_q    <= '0;
            max_q       <= '0;
            nonce_q     <= '0;
            rnd_q       <= '0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            hash_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    header_q    <= bus.header;
                    target_q    <= bus.target;
                    max_q       <= bus.max_nonce;
                    nonce_q     <= '0;
                    found_q     <= 1'b0;
                    nonce_out_q <= '0;
                    hash_out_q  <= '0;
                end
                LOAD: rnd_q <= '0;
                HASH: if (!bus.abort) rnd_q <= rnd_q + RND_W'(1);
                CHECK: if (!bus.abort) begin
                    hash_out_q  <= bus.hash_H;
                    nonce_out_q <= nonce_q;
                    // Increment only when another attempt follows, so max_nonce = all-ones never wraps.
                    if (hit) found_q <= 1'b1;
                    else if (!last_nonce) nonce_q <= nonce_q + NONCE_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.hash_bloque  = {header_q, 32'(nonce_q)};
    assign bus.hash_reset_L = hash_reset_l_c;
    assign bus.hash_fin     = hash_fin_c;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.found        = found_q;
    assign bus.nonce_out    = nonce_out_q;
    assign bus.hash_out     = hash_out_q;
endmodule

// File: tb/tb_micro_ucr_nonce_ctrl.sv
// Scoreboard bench for micro_ucr_nonce_ctrl: a hash stub feeds the DUT, a search-level
// model predicts each done pulse, and a monitor checks every pulse against the queue.
module tb_micro_ucr_nonce_ctrl;
    localparam int HC = 34;
    localparam int NW = 32;

    typedef struct {
        int unsigned  cyc;
        logic         found;
        logic [31:0]  nonce;
        logic [23:0]  h;
        logic [95:0]  hdr;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic        prev_done;
    int          n_cmp;
    int          n_err;
    exp_t        q[$];

    micro_ucr_nonce_ctrl_if #(.NONCE_W(NW)) bus ();

    micro_ucr_nonce_ctrl #(.HASH_CYC(HC), .NONCE_W(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hash core stand-in: a pure function of the nonce presented on hash_bloque.
    function automatic logic [23:0] stub_h(input logic [31:0] n, input logic [1:0] m,
                                           input logic [31:0] s);
        logic [31:0] x;
        case (m)
            2'd0: return 24'h000000;
            2'd1: return (n == 32'd3) ? 24'h0505FF : 24'hFFFFFF;
            2'd2: return 24'h100000;
            default: begin
                x = (n * 32'h9E3779B1) ^ s;
                return x[31:8];
            end
        endcase
    endfunction

    assign bus.hash_H = stub_h(bus.hash_bloque[31:0], mode, seed);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Search-level reference: try nonces in order, stop at first hit or at max_nonce.
    function automatic exp_t model(input logic [95:0] hdr, input logic [7:0] tgt,
                                   input logic [31:0] maxn, input int unsigned c0);
        exp_t e;
        logic [23:0] h;
        e.hdr   = hdr;
        e.found = 1'b0;
        e.nonce = '0;
        e.h     = '0;
        for (longint unsigned n = 0; n <= longint'(maxn); n++) begin
            h       = stub_h(32'(n), mode, seed);
            e.nonce = 32'(n);
            e.h     = h;
            if (h[23:16] < tgt && h[15:8] < tgt) begin
                e.found = 1'b1;
                break;
            end
        end
        e.cyc = c0 + (e.nonce + 1) * (HC + 2) + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            chk("done_pulse_width", prev_done, 1'b0);
            if (q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("found", bus.found, e.found);
                chk("nonce_out", bus.nonce_out, e.nonce);
                chk("hash_out", bus.hash_out, e.h);
                chk("header_latched", bus.hash_bloque[127:32], e.hdr);
            end
        end
        prev_done <= bus.done;
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic run_search(input logic [95:0] hdr, input logic [7:0] tgt,
                              input logic [31:0] maxn, input bit disturb);
        @(posedge clk); #1;
        bus.header    = hdr;
        bus.target    = tgt;
        bus.max_nonce = maxn;
        bus.start     = 1'b1;
        q.push_back(model(hdr, tgt, maxn, cyc));
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (disturb) begin
            repeat (10) @(posedge clk);
            #1;
            bus.header    = ~hdr;
            bus.target    = 8'hFF;
            bus.max_nonce = '0;
            bus.start     = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("hdr_hold_in_hash", bus.hash_bloque[127:32], hdr);
            chk("hash_fin_in_hash", bus.hash_fin, 1'b0);
        end
        wait_idle((int'(maxn) + 2) * (HC + 2) + 20);
    endtask

    task automatic abort_at(input int k, input logic [31:0] exp_nout, input logic [23:0] exp_hout);
        int unsigned c0;
        @(posedge clk); #1;
        bus.header    = 96'hA5A5_0000_1111_2222_3333_4444;
        bus.target    = 8'h10;
        bus.max_nonce = 32'd10;
        bus.start     = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 32'(k)) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_hash_reset_L", bus.hash_reset_L, 1'b0);
        chk("abort_found", bus.found, 1'b0);
        chk("abort_nonce_out", bus.nonce_out, exp_nout);
        chk("abort_hash_out", bus.hash_out, exp_hout);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_stays_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; prev_done = 1'b0;
        mode = 2'd0; seed = 32'h0;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.header = '0; bus.target = '0; bus.max_nonce = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_hash_fin", bus.hash_fin, 1'b1);
        chk("rst_hash_reset_L", bus.hash_reset_L, 1'b0);
        chk("rst_found", bus.found, 1'b0);
        chk("rst_bloque", bus.hash_bloque, 128'h0);
        reset = 1'b0;

        mode = 2'd0;
        run_search(96'h0123_4567_89AB_CDEF_0011_2233, 8'h10, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("found_held", bus.found, 1'b1);

        mode = 2'd1;
        run_search(96'hDEAD_BEEF_CAFE_F00D_1234_5678, 8'h10, 32'd10, 1'b0);

        mode = 2'd2;
        run_search(96'h1111_2222_3333_4444_5555_6666, 8'h10, 32'd2, 1'b0);

        mode = 2'd1;
        abort_at(20, 32'd0, 24'h000000);
        abort_at(50, 32'd0, 24'hFFFFFF);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_ignored", bus.busy, 1'b0);

        mode = 2'd1;
        run_search(96'h7777_8888_9999_AAAA_BBBB_CCCC, 8'h10, 32'd4, 1'b1);

        mode = 2'd0;
        @(posedge clk); #1;
        bus.header = 96'hFFFF_0000_FFFF_0000_FFFF_0000; bus.target = 8'h10;
        bus.max_nonce = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_hash_reset_L", bus.hash_reset_L, 1'b0);
        chk("arst_hash_fin", bus.hash_fin, 1'b1);
        chk("arst_bloque", bus.hash_bloque, 128'h0);
        chk("arst_found_nonce_hash", {bus.found, bus.nonce_out, bus.hash_out}, '0);
        reset = 1'b0;
        run_search(96'h0BAD_F00D_0BAD_F00D_0BAD_F00D, 8'h10, 32'd0, 1'b0);

        mode = 2'd3;
        for (int i = 0; i < 12; i++) begin
            seed = $urandom;
            run_search({$urandom, $urandom, $urandom}, 8'($urandom_range(8'h30, 8'hFF)),
                       32'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
